// File: rtl/fp_sign_pkg.sv
// Shared definitions for the FP sign-resolution pipeline: opcode and
// rounding-mode encodings plus the stage-1 flag payload that travels from
// the capture stage to the resolve stage.
package fp_sign_pkg;

    // Opcode and rounding-mode field widths
    localparam int OPC_W = 2;
    localparam int RND_W = 3;

    // Arithmetic opcodes
    localparam logic [OPC_W-1:0] OP_ADD = 2'b00;
    localparam logic [OPC_W-1:0] OP_SUB = 2'b01;
    localparam logic [OPC_W-1:0] OP_MUL = 2'b10;
    localparam logic [OPC_W-1:0] OP_DIV = 2'b11;

    // IEEE round toward negative infinity
    localparam logic [RND_W-1:0] RND_RDN = 3'b010;

    // Flags computed when a transaction is accepted; everything the
    // combinational resolver needs apart from the exponent difference itself.
    typedef struct packed {
        logic             add_sub;     // opcode is add or sub
        logic             sign_x;      // raw sign of X
        logic             sign_y;      // raw sign of Y (used by mul/div)
        logic             sign_y_eff;  // sign of Y after sub negation
        logic             eff_sub;     // signs differ after sub negation
        logic             d_sign;      // ExpX < ExpY
        logic             d_zero;      // ExpX == ExpY
        logic             man_gt;      // ManY > ManX
        logic             man_eq;      // ManY == ManX
        logic [RND_W-1:0] rnd;         // rounding mode captured with operands
    } s1_flags_t;

    // True for the add/sub opcodes
    function automatic logic is_add_sub(input logic [OPC_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/fp_sign_resolve.sv
// Combinational sign resolution from stage-1 flags: result sign, operand
// swap, exact-cancellation and effective-subtraction outputs.
module fp_sign_resolve
    import fp_sign_pkg::*;
(
    input  s1_flags_t flags,
    output logic      sign,
    output logic      eff_sub,
    output logic      swap,
    output logic      zero
);

    logic mag_y_gt;
    logic mag_eq;

    // Magnitude ordering from exponent difference with significand tie-break
    always_comb begin
        mag_y_gt = flags.d_sign | (flags.d_zero & flags.man_gt);
        mag_eq   = flags.d_zero & flags.man_eq;
    end

    // Result sign and datapath control per operation class
    always_comb begin
        sign    = 1'b0;
        eff_sub = 1'b0;
        swap    = 1'b0;
        zero    = 1'b0;
        if (!flags.add_sub) begin
            // mul/div: sign is just the XOR of operand signs
            sign = flags.sign_x ^ flags.sign_y;
        end else begin
            swap = mag_y_gt;
            if (!flags.eff_sub) begin
                sign = flags.sign_x;
            end else begin
                eff_sub = 1'b1;
                zero    = mag_eq;
                if (mag_eq) begin
                    // exact cancellation: +0 except when rounding toward -inf
                    sign = (flags.rnd == RND_RDN);
                end else if (mag_y_gt) begin
                    sign = flags.sign_y_eff;
                end else begin
                    sign = flags.sign_x;
                end
            end
        end
    end

endmodule

// File: rtl/fp_sign_pipe.sv
// Two-stage pipelined sign resolution for add/sub/mul/div with a
// valid/ready handshake on both sides.
// Optional macro FP_SIGN_RND_MODE_EN adds the RndMode input so exact
// cancellation under round-toward-negative yields -0.
module fp_sign_pipe
    import fp_sign_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [OPC_W-1:0] OpCode,
    input  logic             SignX,
    input  logic             SignY,
    input  logic [EXP_W-1:0] ExpX,
    input  logic [EXP_W-1:0] ExpY,
    input  logic [MAN_W-1:0] ManX,
    input  logic [MAN_W-1:0] ManY,
    input  logic [TAG_W-1:0] InTag,
`ifdef FP_SIGN_RND_MODE_EN
    input  logic [RND_W-1:0] RndMode,
`endif
    output logic             OutValid,
    input  logic             OutReady,
    output logic             OutSign,
    output logic             OutEffSub,
    output logic             OutSwap,
    output logic [EXP_W-1:0] OutExpDiff,
    output logic             OutZeroRes,
    output logic [TAG_W-1:0] OutTag
);

    // Two's-complement magnitude of the low exponent-difference bits; the
    // true magnitude always fits in EXP_W bits, so the MSB is not needed.
    function automatic logic [EXP_W-1:0] exp_mag(input logic neg,
                                                 input logic [EXP_W-1:0] d);
        return neg ? (~d + 1'b1) : d;
    endfunction

    logic                    adv1;
    logic                    adv2;
    logic                    accept;
    logic                    load_p2;

    logic signed [EXP_W:0]   diff_p0;
    s1_flags_t               flags_p0;

    logic                    vld_p1;
    s1_flags_t               flags_p1;
    logic        [EXP_W-1:0] exp_diff_p1;
    logic        [TAG_W-1:0] tag_p1;

    logic                    res_sign;
    logic                    res_eff_sub;
    logic                    res_swap;
    logic                    res_zero;

    // Stage 2 advances when empty or drained; stage 1 when empty or stage 2 moves.
    // Flush blocks acceptance so nothing enters a pipeline being emptied.
    assign adv2    = ~OutValid | OutReady;
    assign adv1    = ~vld_p1 | adv2;
    assign InReady = adv1 & ~Flush;
    assign accept  = InValid & InReady;
    assign load_p2 = adv2 & vld_p1 & ~Flush;

    // ---- stage 0: operand compare and effective-operation flags ----
    always_comb begin
        diff_p0             = $signed({1'b0, ExpX}) - $signed({1'b0, ExpY});
        flags_p0            = '0;
        flags_p0.add_sub    = is_add_sub(OpCode);
        flags_p0.sign_x     = SignX;
        flags_p0.sign_y     = SignY;
        flags_p0.sign_y_eff = SignY ^ (OpCode == OP_SUB);
        flags_p0.eff_sub    = SignX ^ (SignY ^ (OpCode == OP_SUB));
        flags_p0.d_sign     = diff_p0[EXP_W];
        flags_p0.d_zero     = (diff_p0 == '0);
        flags_p0.man_gt     = (ManY > ManX);
        flags_p0.man_eq     = (ManY == ManX);
`ifdef FP_SIGN_RND_MODE_EN
        flags_p0.rnd        = RndMode;
`else
        flags_p0.rnd        = '0;
`endif
    end

    // ---- stage 1 boundary: valid tracking (control, reset) ----
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            vld_p1 <= 1'b0;
        end else if (Flush) begin
            vld_p1 <= 1'b0;
        end else if (adv1) begin
            vld_p1 <= accept;
        end
    end

    // Stage 1 payload captured only on acceptance
    always_ff @(posedge Clk) begin
        if (accept) begin
            flags_p1    <= flags_p0;
            exp_diff_p1 <= diff_p0[EXP_W-1:0];
            tag_p1      <= InTag;
        end
    end

    fp_sign_resolve u_resolve (
        .flags   (flags_p1),
        .sign    (res_sign),
        .eff_sub (res_eff_sub),
        .swap    (res_swap),
        .zero    (res_zero)
    );

    // ---- stage 2 boundary: output valid ----
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            OutValid <= 1'b0;
        end else if (Flush) begin
            OutValid <= 1'b0;
        end else if (adv2) begin
            OutValid <= vld_p1;
        end
    end

    // Output payload; held while the consumer stalls, zero out of reset
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            OutSign    <= 1'b0;
            OutEffSub  <= 1'b0;
            OutSwap    <= 1'b0;
            OutZeroRes <= 1'b0;
            OutExpDiff <= '0;
            OutTag     <= '0;
        end else if (load_p2) begin
            OutSign    <= res_sign;
            OutEffSub  <= res_eff_sub;
            OutSwap    <= res_swap;
            OutZeroRes <= res_zero;
            OutExpDiff <= exp_mag(flags_p1.d_sign, exp_diff_p1);
            OutTag     <= tag_p1;
        end
    end

endmodule

// File: tb/tb_fp_sign_pipe.sv
// Scoreboard bench for fp_sign_pipe: expected results are queued on input
// acceptance by a magnitude-based reference model and popped by a monitor
// on every output handshake.
`timescale 1ns/1ps
module tb_fp_sign_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 4;

    logic             Clk = 1'b0;
    logic             ResetN;
    logic             Flush;
    logic             InValid;
    logic             InReady;
    logic [1:0]       OpCode;
    logic             SignX, SignY;
    logic [EXP_W-1:0] ExpX, ExpY;
    logic [MAN_W-1:0] ManX, ManY;
    logic [TAG_W-1:0] InTag;
    logic             OutValid;
    logic             OutReady;
    logic             OutSign, OutEffSub, OutSwap, OutZeroRes;
    logic [EXP_W-1:0] OutExpDiff;
    logic [TAG_W-1:0] OutTag;
    logic [2:0]       rnd_cur;
`ifdef FP_SIGN_RND_MODE_EN
    logic [2:0]       RndMode;
    assign rnd_cur = RndMode;
`else
    assign rnd_cur = 3'b000;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             sign;
        logic             eff_sub;
        logic             swap;
        logic             zero;
        logic [EXP_W-1:0] ed;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];

    always #5 Clk = ~Clk;

    fp_sign_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .Flush      (Flush),
        .InValid    (InValid),
        .InReady    (InReady),
        .OpCode     (OpCode),
        .SignX      (SignX),
        .SignY      (SignY),
        .ExpX       (ExpX),
        .ExpY       (ExpY),
        .ManX       (ManX),
        .ManY       (ManY),
        .InTag      (InTag),
`ifdef FP_SIGN_RND_MODE_EN
        .RndMode    (RndMode),
`endif
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutSign    (OutSign),
        .OutEffSub  (OutEffSub),
        .OutSwap    (OutSwap),
        .OutExpDiff (OutExpDiff),
        .OutZeroRes (OutZeroRes),
        .OutTag     (OutTag)
    );

    // Reference: compare whole magnitudes as integers, apply IEEE sign rules
    function automatic exp_t ref_model(input logic [1:0] op,
                                       input logic sx, input logic [EXP_W-1:0] ex,
                                       input logic [MAN_W-1:0] mx,
                                       input logic sy, input logic [EXP_W-1:0] ey,
                                       input logic [MAN_W-1:0] my,
                                       input logic [TAG_W-1:0] tag,
                                       input logic [2:0] rnd);
        exp_t   r;
        longint mag_x, mag_y;
        logic   sye;
        mag_x     = longint'(ex) * (longint'(1) << MAN_W) + longint'(mx);
        mag_y     = longint'(ey) * (longint'(1) << MAN_W) + longint'(my);
        r.tag     = tag;
        r.ed      = (ex >= ey) ? ex - ey : ey - ex;
        r.sign    = 1'b0;
        r.eff_sub = 1'b0;
        r.swap    = 1'b0;
        r.zero    = 1'b0;
        if (op == 2'b10 || op == 2'b11) begin
            r.sign = sx ^ sy;
        end else begin
            sye    = (op == 2'b01) ? ~sy : sy;
            r.swap = (mag_y > mag_x);
            if (sx == sye) begin
                r.sign = sx;
            end else begin
                r.eff_sub = 1'b1;
                if (mag_x == mag_y) begin
                    r.zero = 1'b1;
                    r.sign = (rnd == 3'b010);
                end else begin
                    r.sign = r.swap ? sye : sx;
                end
            end
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Push expectation on every accepted input
    always @(negedge Clk) begin
        if (ResetN === 1'b1 && InValid === 1'b1 && InReady === 1'b1)
            sb.push_back(ref_model(OpCode, SignX, ExpX, ManX, SignY, ExpY, ManY, InTag, rnd_cur));
    end

    // Pop and compare on every output handshake
    always @(negedge Clk) begin
        exp_t e;
        if (ResetN === 1'b1 && OutValid === 1'b1 && OutReady === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual_tag=%0d required=no_output", OutTag);
            end else begin
                e = sb.pop_front();
                check("sb_tag", 64'(OutTag), 64'(e.tag));
                check("sb_sign", 64'(OutSign), 64'(e.sign));
                check("sb_effsub", 64'(OutEffSub), 64'(e.eff_sub));
                check("sb_swap", 64'(OutSwap), 64'(e.swap));
                check("sb_zero", 64'(OutZeroRes), 64'(e.zero));
                check("sb_expdiff", 64'(OutExpDiff), 64'(e.ed));
            end
        end
    end

    task automatic rand_payload();
        OpCode = 2'($urandom_range(0, 3));
        SignX  = 1'($urandom_range(0, 1));
        SignY  = 1'($urandom_range(0, 1));
        ExpX   = EXP_W'($urandom);
        case ($urandom_range(0, 3))
            0, 1:    ExpY = ExpX;
            2:       ExpY = ExpX + 1'b1;
            default: ExpY = EXP_W'($urandom);
        endcase
        ManX   = MAN_W'($urandom);
        ManY   = ($urandom_range(0, 2) == 0) ? ManX : MAN_W'($urandom);
        InTag  = TAG_W'($urandom);
`ifdef FP_SIGN_RND_MODE_EN
        RndMode = 3'($urandom_range(0, 7));
`endif
    endtask

    task automatic drain();
        int n = 0;
        InValid  = 1'b0;
        OutReady = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual_pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    // Single transaction into an empty pipe; checks 2-cycle latency and hand values
    task automatic directed(input string nm, input logic [1:0] op,
                            input logic sx, input logic [EXP_W-1:0] ex, input logic [MAN_W-1:0] mx,
                            input logic sy, input logic [EXP_W-1:0] ey, input logic [MAN_W-1:0] my,
                            input logic [2:0] rnd,
                            input logic e_sign, input logic e_effsub, input logic e_swap,
                            input logic e_zero, input logic [EXP_W-1:0] e_ed);
        OutReady = 1'b1;
        OpCode = op; SignX = sx; ExpX = ex; ManX = mx;
        SignY = sy; ExpY = ey; ManY = my; InTag = 4'hA;
`ifdef FP_SIGN_RND_MODE_EN
        RndMode = rnd;
`else
        if (rnd != 3'b000) $display("note: %s rounding mode ignored in this build", nm);
`endif
        InValid = 1'b1;
        @(negedge Clk);
        check({nm, "_inready"}, 64'(InReady), 64'd1);
        @(posedge Clk); #1;
        InValid = 1'b0;
        @(negedge Clk);
        check({nm, "_valid_c1"}, 64'(OutValid), 64'd0);
        @(negedge Clk);
        check({nm, "_valid_c2"}, 64'(OutValid), 64'd1);
        check({nm, "_sign"}, 64'(OutSign), 64'(e_sign));
        check({nm, "_effsub"}, 64'(OutEffSub), 64'(e_effsub));
        check({nm, "_swap"}, 64'(OutSwap), 64'(e_swap));
        check({nm, "_zero"}, 64'(OutZeroRes), 64'(e_zero));
        check({nm, "_expdiff"}, 64'(OutExpDiff), 64'(e_ed));
        @(posedge Clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit hold;
        ResetN = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        OpCode = 2'b00; SignX = 1'b0; SignY = 1'b0; ExpX = '0; ExpY = '0;
        ManX = '0; ManY = '0; InTag = '0;
`ifdef FP_SIGN_RND_MODE_EN
        RndMode = 3'b000;
`endif
        #12;
        check("rst_outvalid", 64'(OutValid), 64'd0);
        check("rst_sign", 64'({OutSign, OutEffSub, OutSwap, OutZeroRes}), 64'd0);
        check("rst_expdiff", 64'(OutExpDiff), 64'd0);
        check("rst_tag", 64'(OutTag), 64'd0);
        @(posedge Clk); #1;
        ResetN = 1'b1;
        @(negedge Clk);
        check("rst_inready", 64'(InReady), 64'd1);
        @(posedge Clk); #1;

        // Directed cases (operands in IEEE single unpacked form)
        directed("add_1p5_m2", 2'b00, 1'b0, 8'd127, 23'h400000, 1'b1, 8'd128, 23'h0, 3'b000,
                 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        directed("sub_m3_m3", 2'b01, 1'b1, 8'd128, 23'h400000, 1'b1, 8'd128, 23'h400000, 3'b000,
                 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
`ifdef FP_SIGN_RND_MODE_EN
        directed("sub_m3_m3_rdn", 2'b01, 1'b1, 8'd128, 23'h400000, 1'b1, 8'd128, 23'h400000, 3'b010,
                 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
`endif
        directed("mul_m1_p1", 2'b10, 1'b1, 8'd127, 23'h0, 1'b0, 8'd127, 23'h0, 3'b000,
                 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        directed("div_neg_neg", 2'b11, 1'b1, 8'd130, 23'h5, 1'b1, 8'd127, 23'h9, 3'b000,
                 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        directed("add_max_expdiff", 2'b00, 1'b0, 8'd0, 23'h0, 1'b1, 8'd255, 23'h0, 3'b000,
                 1'b1, 1'b1, 1'b1, 1'b0, 8'd255);
        directed("add_man_tiebreak", 2'b00, 1'b0, 8'd100, 23'h5, 1'b1, 8'd100, 23'h9, 3'b000,
                 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        directed("sub_x_larger", 2'b01, 1'b1, 8'd100, 23'h9, 1'b1, 8'd100, 23'h5, 3'b000,
                 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        drain();

        // Back-to-back stream of 8 tags with a consumer stall on cycles 3..6
        begin
            int i = 0;
            int c = 0;
            int last = -1;
            while (i < 8 && c < 100) begin
                OutReady = !(c >= 3 && c <= 6);
                if (i != last) begin
                    rand_payload();
                    InTag = TAG_W'(i);
                    last  = i;
                end
                InValid = 1'b1;
                @(negedge Clk);
                if (c == 3) check("stream_full_inready", 64'(InReady), 64'd0);
                if (c == 7) check("stream_resume_inready", 64'(InReady), 64'd1);
                if (InReady) i++;
                @(posedge Clk); #1;
                c++;
            end
            drain();
        end

        // Randomized traffic with random consumer back-pressure
        hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                rand_payload();
                InValid = ($urandom_range(0, 4) != 0);
            end
            OutReady = ($urandom_range(0, 3) != 0);
            @(negedge Clk);
            hold = InValid && !InReady;
            @(posedge Clk); #1;
        end
        drain();

        // Asynchronous reset in the middle of a stream
        OutReady = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rand_payload();
            InValid = 1'b1;
            @(posedge Clk); #1;
        end
        #2;
        ResetN  = 1'b0;
        InValid = 1'b0;
        #1;
        check("rst_mid_outvalid", 64'(OutValid), 64'd0);
        sb.delete();
        @(posedge Clk); #1;
        ResetN = 1'b1;
        directed("post_rst_add", 2'b00, 1'b0, 8'd127, 23'h400000, 1'b1, 8'd128, 23'h0, 3'b000,
                 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        drain();

        // Flush with both stages full and an input on offer
        OutReady = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rand_payload();
            InValid = 1'b1;
            @(negedge Clk);
            check("flush_fill_inready", 64'(InReady), 64'd1);
            @(posedge Clk); #1;
        end
        rand_payload();
        InValid = 1'b1;
        Flush   = 1'b1;
        @(negedge Clk);
        check("flush_inready", 64'(InReady), 64'd0);
        check("flush_full_valid", 64'(OutValid), 64'd1);
        @(posedge Clk); #1;
        Flush   = 1'b0;
        InValid = 1'b0;
        @(negedge Clk);
        check("flush_outvalid", 64'(OutValid), 64'd0);
        sb.delete();
        OutReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("flush_no_ghost", 64'(OutValid), 64'd0);
        end
        @(posedge Clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
